// File: rtl/switch_allocator.sv
// Five-output switch allocator for a P/E/S/W/N mesh router: round-robin per output, wormhole lock head->tail.
// Optional sticky illegal-destination flags are enabled by defining SA_BAD_DST_ERR_EN.
module switch_allocator #(
  parameter int RR_INIT     = 0,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_req,
  input  logic [14:0] in_dst,
  input  logic [4:0]  in_tail,
  input  logic [4:0]  out_ready,
  output logic [4:0]  in_gnt,
  output logic [4:0]  proc_sel_code,
  output logic [4:0]  east_sel_code,
  output logic [4:0]  south_sel_code,
  output logic [4:0]  west_sel_code,
`ifdef SA_BAD_DST_ERR_EN
  output logic [4:0]  north_sel_code,
  output logic [4:0]  bad_dst_err
`else
  output logic [4:0]  north_sel_code
`endif
);

  localparam int NP    = 5;
  localparam int CNT_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_PKT_LEN > 0) ? MAX_PKT_LEN - 1 : 0);
  localparam logic [2:0] PTR_INIT = 3'(RR_INIT);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       r_state [NP];
  logic [2:0]       r_owner [NP];
  logic [2:0]       r_ptr   [NP];
  logic [CNT_W-1:0] r_cnt   [NP];
  logic [4:0]       r_sel   [NP];

  logic [2:0] w_dst   [NP];
  logic [4:0] w_legal;
  logic       w_fire  [NP];
  logic [2:0] w_win   [NP];
  logic [4:0] w_gnt   [NP];
  logic       w_last  [NP];
  logic [4:0] w_gnt_all;

  // Stage p0: decode destinations and arbitrate every output
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      w_dst[i]   = in_dst[3*i +: 3];
      w_legal[i] = (w_dst[i] <= 3'd4) && (w_dst[i] != 3'(i));
    end
  end

  always_comb begin
    logic [2:0] idx;
    idx = '0;
    w_gnt_all = '0;
    for (int o = 0; o < NP; o++) begin
      w_fire[o] = 1'b0;
      w_win[o]  = r_owner[o];
      w_last[o] = 1'b0;
      if (r_state[o] == ST_IDLE) begin
        if (out_ready[o]) begin
          for (int k = 1; k <= NP; k++) begin
            idx = 3'((int'(r_ptr[o]) + k) % NP);
            if (!w_fire[o] && in_req[idx] && w_legal[idx] && (w_dst[idx] == 3'(o))) begin
              w_fire[o] = 1'b1;
              w_win[o]  = idx;
            end
          end
        end
      end else if (in_req[r_owner[o]] && out_ready[o]) begin
        w_fire[o] = 1'b1;
      end
      // Length cap counts this grant: first grant of a packet is number one
      if (MAX_PKT_LEN > 0) begin
        if (r_state[o] == ST_IDLE) w_last[o] = (MAX_PKT_LEN == 1);
        else                       w_last[o] = (r_cnt[o] == LAST_CNT);
      end
      w_gnt[o]  = w_fire[o] ? (5'b00001 << w_win[o]) : 5'b00000;
      w_gnt_all = w_gnt_all | w_gnt[o];
    end
  end

  assign in_gnt = rst ? 5'b00000 : w_gnt_all;

  // Stage p1: register select codes and advance per-output lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= PTR_INIT;
        r_cnt[o]   <= '0;
        r_sel[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        r_sel[o] <= w_gnt[o];
        if (w_fire[o]) begin
          if (r_state[o] == ST_IDLE) begin
            r_ptr[o]   <= w_win[o];
            r_owner[o] <= w_win[o];
            r_cnt[o]   <= CNT_W'(1);
          end else begin
            r_cnt[o]   <= r_cnt[o] + CNT_W'(1);
          end
          r_state[o] <= (in_tail[w_win[o]] || w_last[o]) ? ST_IDLE : ST_LOCKED;
        end
      end
    end
  end

`ifdef SA_BAD_DST_ERR_EN
  logic [4:0] r_bad;
  always_ff @(posedge clk) begin
    if (rst) r_bad <= '0;
    else     r_bad <= r_bad | (in_req & ~w_legal);
  end
  assign bad_dst_err = r_bad;
`endif

  assign proc_sel_code  = r_sel[0];
  assign east_sel_code  = r_sel[1];
  assign south_sel_code = r_sel[2];
  assign west_sel_code  = r_sel[3];
  assign north_sel_code = r_sel[4];

endmodule
